// File: rtl/alu_ctrl.sv
// alu_ctrl: sequencing controller for an external combinational ALU.
// Accepts one operation, drives the operands and select bits to the ALU,
// captures the result and holds it until the consumer takes it.
// Define ALU_CTRL_STATS_EN to add the completed-operation counter
// (port op_count, width CNT_W).
module alu_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_s0,
  output logic        alu_s1,
  output logic        alu_s2,
  input  logic [32:0] alu_res,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [32:0] res_data,
  output logic        res_zero,
  output logic        res_err
`ifdef ALU_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] op_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [32:0] res_data_q, res_data_d;
  logic        res_zero_q, res_zero_d;
  logic        res_err_q, res_err_d;
  logic        accept;

  // Handshake: ready only in IDLE and never while reset is asserted.
  always_comb begin
    op_ready = (state_q == ST_IDLE) && !rst;
    accept   = op_valid && op_ready;
  end

  // Next-state and datapath-register update.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    res_data_d = res_data_q;
    res_zero_d = res_zero_q;
    res_err_d  = res_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_a_d  = op_a;
          alu_b_d  = op_b;
          alu_op_d = op_code;
          if (op_code > 3'd4) begin
            // Illegal code: skip the ALU and report a zero error result.
            res_data_d = '0;
            res_zero_d = 1'b1;
            res_err_d  = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        res_data_d = alu_res;
        res_zero_d = (alu_res[31:0] == '0);
        res_err_d  = 1'b0;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      res_data_q <= res_data_d;
      res_zero_q <= res_zero_d;
      res_err_q  <= res_err_d;
    end
  end

  // Output mapping.
  always_comb begin
    alu_a     = alu_a_q;
    alu_b     = alu_b_q;
    alu_s0    = alu_op_q[0];
    alu_s1    = alu_op_q[1];
    alu_s2    = alu_op_q[2];
    res_valid = (state_q == ST_DONE);
    res_data  = res_data_q;
    res_zero  = res_zero_q;
    res_err   = res_err_q;
  end

`ifdef ALU_CTRL_STATS_EN
  logic [CNT_W-1:0] op_count_q, op_count_d;

  // Count every result handed to the consumer; wraps naturally.
  always_comb begin
    op_count_d = op_count_q;
    if ((state_q == ST_DONE) && res_ready) begin
      op_count_d = op_count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  // Counter output.
  always_comb begin
    op_count = op_count_q;
  end
`endif

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of completed-operation counter (ALU_CTRL_STATS_EN only).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 op_valid  input  1  request holds valid operation.
REQ-005 op_ready  output  1  block accepts a request this cycle.
REQ-006 op_code  input  3  {s2,s1,s0}: 000 add, 001 sub, 010 and, 011 or, 100 nor; 101-111 illegal.
REQ-007 op_a  input  32  operand A.
REQ-008 op_b  input  32  operand B.
REQ-009 alu_a  output  32  operand A driven to the external combinational ALU.
REQ-010 alu_b  output  32  operand B driven to the ALU.
REQ-011 alu_s0, alu_s1, alu_s2  output  1 each  ALU select bits.
REQ-012 alu_res  input  33  ALU result, bit 32 = sign extension of bit 31.
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  consumer takes result this cycle.
REQ-015 res_data  output  33  captured result.
REQ-016 res_zero  output  1  res_data[31:0] == 0.
REQ-017 res_err  output  1  request carried an illegal op_code.
REQ-018 op_count  output  CNT_W  completed results (ALU_CTRL_STATS_EN only).

Function
REQ-019 FSM states IDLE, EXEC, DONE; op_ready SHALL be 1 exactly in IDLE.
REQ-020 IDLE: on op_valid&&op_ready, register op_a/op_b/op_code onto alu_a/alu_b/alu_s*; go EXEC for legal code, DONE for illegal.
REQ-021 EXEC: ALU inputs held stable one full cycle; at its end capture alu_res into res_data, go DONE.
REQ-022 DONE: res_valid=1; res_data, res_zero, res_err SHALL hold stable until res_ready sampled high, then go IDLE.
REQ-023 Legal latency: accept at edge T, res_valid high after edge T+2; illegal: after edge T+1.
REQ-024 Illegal code: res_data=0, res_zero=1, res_err=1; ALU result ignored; alu_* still updated.
REQ-025 res_err SHALL be 0 for legal codes; res_zero computed from captured value, registered with it.
REQ-026 alu_a/alu_b/alu_s* SHALL keep last issued values in IDLE and DONE (no toggling without accept).
REQ-027 Back-to-back: res_ready high on first DONE cycle returns to IDLE next cycle; new request accepted there; max throughput one op per 3 cycles (legal).
REQ-028 op_valid deassertion while not ready has no effect; no request is lost or duplicated.

Reset
REQ-029 rst high SHALL immediately force IDLE; res_valid, res_err, res_data, res_zero, alu_a, alu_b, alu_s*, op_count to 0.
REQ-030 Reset mid-EXEC or mid-DONE discards the operation; no result emitted after release.
REQ-031 op_ready SHALL be 0 while rst is high, 1 in first cycle after release.

Configuration
REQ-032 Macro ALU_CTRL_STATS_EN defined: op_count port present, increments by 1 on each DONE&&res_ready (legal and illegal), wraps to 0 at 2^CNT_W-1.
REQ-033 Macro absent: op_count port and counter logic absent; all other behaviour identical.

Verification
REQ-034 Add: op_code=000, a=5, b=7, res_ready=1 -> res_valid after T+2, res_data=0x0_0000000C, res_zero=0, res_err=0.
REQ-035 Sub: code=001, a=3, b=5 -> res_data=0x1_FFFFFFFE; a=b=9 -> res_data=0, res_zero=1.
REQ-036 Illegal: code=110 -> res_valid after T+1, res_data=0, res_err=1, res_zero=1; ALU not waited on.
REQ-037 Backpressure: res_ready=0 for 10 cycles in DONE -> res_data stable, op_ready=0, new op_valid ignored; res_ready=1 -> IDLE next cycle, then next op accepted.
REQ-038 Reset during EXEC (a=1,b=1,code=000) -> res_valid never rises, all outputs 0, op_ready=1 after release.
REQ-039 With ALU_CTRL_STATS_EN, CNT_W=2: 5 completed ops -> op_count sequence 1,2,3,0,1.
